hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard controller for the five-stage core: replaces the purely combinational stall/flush logic with forwarding selection, load-use detection, a multi-cycle mul/div busy FSM, squashing of a stale in-flight fetch after a redirect, and a stall-cycle performance counter. It sits beside the pipeline. It takes register addresses and stage status from decode/execute/memory/writeback and the bus-ready signals from busio. It drives stall/invalidate to every stage register and forwarding selects to decode.

---
 rtl/hazard_scoreboard.sv | 207 ++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline hazard controller for the five-stage core. Selects operand
// forwarding for decode, detects RAW / load-use and CSR hazards, sequences
// multi-cycle mul/div operations occupying execute, squashes a stale in-flight
// fetch after a redirect, and counts fetch-stall cycles.
//
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   rs1/rs2_address_decode, _read      decode source registers and use flags
//   rd_address/rd_write_execute/memory destinations in flight
//   load_execute, muldiv_execute       kind of instruction held in execute
//   csr_write_execute/memory/writeback CSR write in flight
//   branch_taken, mret_memory,
//   mret_writeback, traped             redirect sources
//   fetch_ready, mem_ready             bus handshakes from busio
//   perf_clear                         synchronous clear of the stall counter
//   stall_*                            hold the stage register
//   invalidate_*                       load a bubble into the stage register
//   fwd_rs1, fwd_rs2                   0 regfile, 1 execute result, 2 memory result
//   muldiv_busy                        mul/div sequencer is in BUSY
//   perf_stall_count                   saturating count of fetch-stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W    = 5,
    parameter int FORWARD_EN    = 1,
    parameter int MULDIV_CYCLES = 34,
    parameter int PERF_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_address_decode,
    input  logic [REG_ADDR_W-1:0] rs2_address_decode,
    input  logic                  rs1_read_decode,
    input  logic                  rs2_read_decode,
    input  logic [REG_ADDR_W-1:0] rd_address_execute,
    input  logic [REG_ADDR_W-1:0] rd_address_memory,
    input  logic                  rd_write_execute,
    input  logic                  rd_write_memory,
    input  logic                  load_execute,
    input  logic                  muldiv_execute,
    input  logic                  csr_write_execute,
    input  logic                  csr_write_memory,
    input  logic                  csr_write_writeback,
    input  logic                  branch_taken,
    input  logic                  mret_memory,
    input  logic                  mret_writeback,
    input  logic                  traped,
    input  logic                  fetch_ready,
    input  logic                  mem_ready,
    input  logic                  perf_clear,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  stall_execute,
    output logic                  stall_memory,
    output logic                  invalidate_fetch,
    output logic                  invalidate_decode,
    output logic                  invalidate_execute,
    output logic                  invalidate_memory,
    output logic [1:0]            fwd_rs1,
    output logic [1:0]            fwd_rs2,
    output logic                  muldiv_busy,
    output logic [PERF_W-1:0]     perf_stall_count
);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXECUTE = 2'd1;
    localparam logic [1:0] FWD_MEMORY  = 2'd2;

    // The counter holds at most MULDIV_CYCLES-2.
    localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);
    localparam logic MULTI_CYCLE = (MULDIV_CYCLES > 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             squash_pending, squash_next;

    logic rs1_match_ex, rs1_match_mem, rs2_match_ex, rs2_match_mem;
    logic raw_stall, csr_stall, flush, redir, muldiv_stall;

    // ------------------------------------------------------------------
    // Source/destination matching. x0 is hard-wired zero, never a hazard.
    // ------------------------------------------------------------------
    assign rs1_match_ex  = rs1_read_decode && rd_write_execute &&
                           (rd_address_execute == rs1_address_decode) &&
                           (rs1_address_decode != '0);
    assign rs1_match_mem = rs1_read_decode && rd_write_memory &&
                           (rd_address_memory == rs1_address_decode) &&
                           (rs1_address_decode != '0);
    assign rs2_match_ex  = rs2_read_decode && rd_write_execute &&
                           (rd_address_execute == rs2_address_decode) &&
                           (rs2_address_decode != '0);
    assign rs2_match_mem = rs2_read_decode && rd_write_memory &&
                           (rd_address_memory == rs2_address_decode) &&
                           (rs2_address_decode != '0);

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        fwd_rs1   = FWD_REGFILE;
        fwd_rs2   = FWD_REGFILE;
        raw_stall = 1'b0;
        if (FORWARD_EN != 0) begin
            // Execute is the younger producer, so it wins over memory.
            if (rs1_match_ex)       fwd_rs1 = FWD_EXECUTE;
            else if (rs1_match_mem) fwd_rs1 = FWD_MEMORY;
            if (rs2_match_ex)       fwd_rs2 = FWD_EXECUTE;
            else if (rs2_match_mem) fwd_rs2 = FWD_MEMORY;
            // Load data is not available from execute: one bubble needed.
            raw_stall = (rs1_match_ex || rs2_match_ex) && load_execute;
        end else begin
            raw_stall = rs1_match_ex || rs1_match_mem ||
                        rs2_match_ex || rs2_match_mem;
        end
    end

    assign csr_stall = csr_write_execute || csr_write_memory || csr_write_writeback;
    assign flush     = branch_taken || mret_writeback || traped;
    assign redir     = flush || mret_memory;

    // A single-cycle mul/div never stalls; otherwise execute is held until
    // the last BUSY cycle (cnt == 0).
    assign muldiv_stall = MULTI_CYCLE && muldiv_execute && !redir &&
                          !((state == MD_BUSY) && (cnt == '0));

    // ------------------------------------------------------------------
    // Stall / invalidate. Invalidating a stage overrides stalling it.
    // ------------------------------------------------------------------
    assign invalidate_fetch   = redir || !fetch_ready || squash_pending;
    assign invalidate_decode  = redir || raw_stall || csr_stall;
    assign invalidate_execute = redir || muldiv_stall;
    assign invalidate_memory  = flush || !mem_ready;

    assign stall_memory  = 1'b0;
    assign stall_execute = !invalidate_execute && !mem_ready;
    assign stall_decode  = !invalidate_decode && (stall_execute || muldiv_stall);
    assign stall_fetch   = !invalidate_fetch &&
                           (stall_decode || raw_stall || csr_stall || muldiv_stall);

    assign muldiv_busy = (state == MD_BUSY);

    // ------------------------------------------------------------------
    // Mul/div sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            MD_IDLE: begin
                if (muldiv_execute && !redir && MULTI_CYCLE) begin
                    state_next = MD_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (redir) begin
                    state_next = MD_IDLE;
                    cnt_next   = '0;
                end else if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (mem_ready) begin
                    state_next = MD_IDLE;
                end
            end
        endcase
    end

    // A redirect while the bus has not yet returned the old fetch leaves a
    // stale word in flight; drop it when it finally arrives.
    assign squash_next = !fetch_ready && (redir || squash_pending);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= MD_IDLE;
            cnt            <= '0;
            squash_pending <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            squash_pending <= squash_next;
        end
    end

    // ------------------------------------------------------------------
    // Saturating fetch-stall counter; clear wins over increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_count <= '0;
        end else if (perf_clear) begin
            perf_stall_count <= '0;
        end else if (stall_fetch && (perf_stall_count != '1)) begin
            perf_stall_count <= perf_stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Drives two configurations of hazard_scoreboard with identical stimulus:
//   dut_a: FORWARD_EN=1, MULDIV_CYCLES=4, PERF_W=32
//   dut_b: FORWARD_EN=0, MULDIV_CYCLES=1, PERF_W=4
// Expected outputs are queued as each step is driven and popped/compared at
// the following falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_address_decode, rs2_address_decode;
    logic       rs1_read_decode, rs2_read_decode;
    logic [4:0] rd_address_execute, rd_address_memory;
    logic       rd_write_execute, rd_write_memory;
    logic       load_execute, muldiv_execute;
    logic       csr_write_execute, csr_write_memory, csr_write_writeback;
    logic       branch_taken, mret_memory, mret_writeback, traped;
    logic       fetch_ready, mem_ready, perf_clear;

    logic        a_stall_f, a_stall_d, a_stall_e, a_stall_m;
    logic        a_inv_f, a_inv_d, a_inv_e, a_inv_m;
    logic [1:0]  a_fwd1, a_fwd2;
    logic        a_busy;
    logic [31:0] a_perf;

    logic        b_stall_f, b_stall_d, b_stall_e, b_stall_m;
    logic        b_inv_f, b_inv_d, b_inv_e, b_inv_m;
    logic [1:0]  b_fwd1, b_fwd2;
    logic        b_busy;
    logic [3:0]  b_perf;

    // Packed view: {stall f,d,e,m}_{inv f,d,e,m}_fwd1_fwd2_busy
    logic [12:0] ctrl_a, ctrl_b;
    assign ctrl_a = {a_stall_f, a_stall_d, a_stall_e, a_stall_m,
                     a_inv_f, a_inv_d, a_inv_e, a_inv_m, a_fwd1, a_fwd2, a_busy};
    assign ctrl_b = {b_stall_f, b_stall_d, b_stall_e, b_stall_m,
                     b_inv_f, b_inv_d, b_inv_e, b_inv_m, b_fwd1, b_fwd2, b_busy};

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .FORWARD_EN(1), .MULDIV_CYCLES(4), .PERF_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .rs1_address_decode(rs1_address_decode), .rs2_address_decode(rs2_address_decode),
        .rs1_read_decode(rs1_read_decode), .rs2_read_decode(rs2_read_decode),
        .rd_address_execute(rd_address_execute), .rd_address_memory(rd_address_memory),
        .rd_write_execute(rd_write_execute), .rd_write_memory(rd_write_memory),
        .load_execute(load_execute), .muldiv_execute(muldiv_execute),
        .csr_write_execute(csr_write_execute), .csr_write_memory(csr_write_memory),
        .csr_write_writeback(csr_write_writeback),
        .branch_taken(branch_taken), .mret_memory(mret_memory),
        .mret_writeback(mret_writeback), .traped(traped),
        .fetch_ready(fetch_ready), .mem_ready(mem_ready), .perf_clear(perf_clear),
        .stall_fetch(a_stall_f), .stall_decode(a_stall_d),
        .stall_execute(a_stall_e), .stall_memory(a_stall_m),
        .invalidate_fetch(a_inv_f), .invalidate_decode(a_inv_d),
        .invalidate_execute(a_inv_e), .invalidate_memory(a_inv_m),
        .fwd_rs1(a_fwd1), .fwd_rs2(a_fwd2), .muldiv_busy(a_busy),
        .perf_stall_count(a_perf)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .FORWARD_EN(0), .MULDIV_CYCLES(1), .PERF_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_address_decode(rs1_address_decode), .rs2_address_decode(rs2_address_decode),
        .rs1_read_decode(rs1_read_decode), .rs2_read_decode(rs2_read_decode),
        .rd_address_execute(rd_address_execute), .rd_address_memory(rd_address_memory),
        .rd_write_execute(rd_write_execute), .rd_write_memory(rd_write_memory),
        .load_execute(load_execute), .muldiv_execute(muldiv_execute),
        .csr_write_execute(csr_write_execute), .csr_write_memory(csr_write_memory),
        .csr_write_writeback(csr_write_writeback),
        .branch_taken(branch_taken), .mret_memory(mret_memory),
        .mret_writeback(mret_writeback), .traped(traped),
        .fetch_ready(fetch_ready), .mem_ready(mem_ready), .perf_clear(perf_clear),
        .stall_fetch(b_stall_f), .stall_decode(b_stall_d),
        .stall_execute(b_stall_e), .stall_memory(b_stall_m),
        .invalidate_fetch(b_inv_f), .invalidate_decode(b_inv_d),
        .invalidate_execute(b_inv_e), .invalidate_memory(b_inv_m),
        .fwd_rs1(b_fwd1), .fwd_rs2(b_fwd2), .muldiv_busy(b_busy),
        .perf_stall_count(b_perf)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef enum int {SEL_CTRL_A, SEL_CTRL_B, SEL_PERF_A, SEL_PERF_B} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_ctrl(input string tag, input logic [12:0] a, input logic [12:0] b);
        exp_t e;
        e.tag = {tag, "/a"}; e.sel = SEL_CTRL_A; e.exp = {19'b0, a}; sb.push_back(e);
        e.tag = {tag, "/b"}; e.sel = SEL_CTRL_B; e.exp = {19'b0, b}; sb.push_back(e);
    endtask

    task automatic expect_ctrl_a(input string tag, input logic [12:0] a);
        exp_t e;
        e.tag = {tag, "/a"}; e.sel = SEL_CTRL_A; e.exp = {19'b0, a}; sb.push_back(e);
    endtask

    task automatic expect_perf(input string tag, input logic [31:0] a, input logic [3:0] b);
        exp_t e;
        e.tag = {tag, "/perf_a"}; e.sel = SEL_PERF_A; e.exp = a;           sb.push_back(e);
        e.tag = {tag, "/perf_b"}; e.sel = SEL_PERF_B; e.exp = {28'b0, b};  sb.push_back(e);
    endtask

    // Pops every queued expectation and compares it with the live outputs.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_CTRL_A: obs = {19'b0, ctrl_a};
                SEL_CTRL_B: obs = {19'b0, ctrl_b};
                SEL_PERF_A: obs = a_perf;
                SEL_PERF_B: obs = {28'b0, b_perf};
                default:    obs = 'x;
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic set_idle();
        rs1_address_decode  = '0; rs2_address_decode = '0;
        rs1_read_decode     = 0;  rs2_read_decode    = 0;
        rd_address_execute  = '0; rd_address_memory  = '0;
        rd_write_execute    = 0;  rd_write_memory    = 0;
        load_execute        = 0;  muldiv_execute     = 0;
        csr_write_execute   = 0;  csr_write_memory   = 0;
        csr_write_writeback = 0;
        branch_taken        = 0;  mret_memory        = 0;
        mret_writeback      = 0;  traped             = 0;
        fetch_ready         = 1;  mem_ready          = 1;
        perf_clear          = 0;
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic begin_step();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic end_step();
        @(negedge clk);
        check();
    endtask

    localparam logic [12:0] ALL_ZERO   = 13'b0000_0000_00_00_0;
    localparam logic [12:0] RAW_STALL  = 13'b1000_0100_00_00_0;
    localparam logic [12:0] MD_STALL   = 13'b1100_0010_00_00_0;
    localparam logic [12:0] MD_STALL_B = 13'b1100_0010_00_00_1;
    localparam logic [12:0] FLUSH_ALL  = 13'b0000_1111_00_00_0;
    localparam logic [12:0] INV_FETCH  = 13'b0000_1000_00_00_0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        set_idle();

        // Reset state
        #2;
        expect_ctrl("reset", ALL_ZERO, ALL_ZERO);
        expect_perf("reset", 32'd0, 4'd0);
        end_step();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load-use on x5
        begin_step();
        load_execute = 1; rd_write_execute = 1; rd_address_execute = 5'd5;
        rs1_read_decode = 1; rs1_address_decode = 5'd5;
        expect_ctrl("load_use", 13'b1000_0100_01_00_0, RAW_STALL);
        end_step();

        begin_step();
        rd_write_memory = 1; rd_address_memory = 5'd5;
        rs1_read_decode = 1; rs1_address_decode = 5'd5;
        expect_ctrl("load_fwd_mem", 13'b0000_0000_10_00_0, RAW_STALL);
        end_step();

        // x0 never matches
        begin_step();
        rd_write_execute = 1; rd_address_execute = 5'd0;
        rs1_read_decode = 1; rs1_address_decode = 5'd0;
        expect_ctrl("x0", ALL_ZERO, ALL_ZERO);
        end_step();

        // x7 in execute and memory: execute has priority; rs2 unused
        begin_step();
        rd_write_execute = 1; rd_address_execute = 5'd7;
        rd_write_memory  = 1; rd_address_memory  = 5'd7;
        rs1_read_decode = 1; rs1_address_decode = 5'd7;
        rs2_read_decode = 0; rs2_address_decode = 5'd7;
        expect_ctrl("x7_ex", 13'b0000_0000_01_00_0, RAW_STALL);
        end_step();

        // x7 now in memory, rs2 reads x3 from execute
        begin_step();
        rd_write_execute = 1; rd_address_execute = 5'd3;
        rd_write_memory  = 1; rd_address_memory  = 5'd7;
        rs1_read_decode = 1; rs1_address_decode = 5'd7;
        rs2_read_decode = 1; rs2_address_decode = 5'd3;
        expect_ctrl("x7_mem", 13'b0000_0000_10_01_0, RAW_STALL);
        end_step();

        // x7 has left memory
        begin_step();
        rd_address_execute = 5'd3; rd_address_memory = 5'd7;
        rs1_read_decode = 1; rs1_address_decode = 5'd7;
        rs2_read_decode = 1; rs2_address_decode = 5'd3;
        expect_ctrl("x7_gone", ALL_ZERO, ALL_ZERO);
        end_step();

        // Mul/div: 3 stall cycles, busy cycles 2..4, advance on cycle 4
        begin_step(); muldiv_execute = 1;
        expect_ctrl("md_c1", MD_STALL, ALL_ZERO); end_step();
        begin_step(); muldiv_execute = 1;
        expect_ctrl("md_c2", MD_STALL_B, ALL_ZERO); end_step();
        begin_step(); muldiv_execute = 1;
        expect_ctrl("md_c3", MD_STALL_B, ALL_ZERO); end_step();
        begin_step(); muldiv_execute = 1;
        expect_ctrl("md_c4", 13'b0000_0000_00_00_1, ALL_ZERO); end_step();
        begin_step();
        expect_ctrl("md_done", ALL_ZERO, ALL_ZERO); end_step();

        // Trap during BUSY cycle 2 aborts the mul/div
        begin_step(); muldiv_execute = 1;
        expect_ctrl("trap_c1", MD_STALL, ALL_ZERO); end_step();
        begin_step(); muldiv_execute = 1; traped = 1;
        expect_ctrl("trap_c2", 13'b0000_1111_00_00_1, FLUSH_ALL); end_step();
        begin_step();
        expect_ctrl("trap_idle", ALL_ZERO, ALL_ZERO); end_step();

        // Branch with fetch not ready; fetch_ready returns 3 cycles later
        begin_step(); branch_taken = 1; fetch_ready = 0;
        expect_ctrl("sq_redir", FLUSH_ALL, FLUSH_ALL); end_step();
        for (int i = 0; i < 2; i++) begin
            begin_step(); fetch_ready = 0;
            expect_ctrl("sq_wait", INV_FETCH, INV_FETCH); end_step();
        end
        begin_step();
        expect_ctrl("sq_stale", INV_FETCH, INV_FETCH); end_step();
        begin_step();
        expect_ctrl("sq_clear", ALL_ZERO, ALL_ZERO); end_step();

        // Branch with fetch ready: nothing to squash
        begin_step(); branch_taken = 1;
        expect_ctrl("br_ready", FLUSH_ALL, FLUSH_ALL); end_step();
        begin_step();
        expect_ctrl("br_no_sq", ALL_ZERO, ALL_ZERO); end_step();

        // Memory not ready
        begin_step(); mem_ready = 0;
        expect_ctrl("mem_wait", 13'b1110_0001_00_00_0, 13'b1110_0001_00_00_0); end_step();

        // Reset while BUSY returns to IDLE immediately
        begin_step(); muldiv_execute = 1;
        expect_ctrl_a("rst_md_c1", MD_STALL); end_step();
        begin_step(); muldiv_execute = 1;
        expect_ctrl_a("rst_md_c2", MD_STALL_B); end_step();
        begin_step(); reset = 1'b0;
        expect_ctrl("rst_mid_busy", ALL_ZERO, ALL_ZERO);
        expect_perf("rst_mid_busy", 32'd0, 4'd0);
        end_step();
        begin_step(); reset = 1'b1;
        end_step();

        // Perf counter: clear, 10 stalls, clear-with-stall, 20 stalls
        begin_step(); perf_clear = 1;
        expect_ctrl("perf_clr0", ALL_ZERO, ALL_ZERO); end_step();
        for (int i = 0; i < 10; i++) begin
            begin_step(); csr_write_execute = 1;
            if (i == 0) expect_perf("perf_start", 32'd0, 4'd0);
            expect_ctrl("csr_stall", RAW_STALL, RAW_STALL);
            end_step();
        end
        begin_step(); perf_clear = 1; csr_write_memory = 1;
        expect_perf("perf_10", 32'd10, 4'd10);
        expect_ctrl("csr_clr", RAW_STALL, RAW_STALL);
        end_step();
        for (int i = 0; i < 20; i++) begin
            begin_step(); csr_write_writeback = 1;
            if (i == 0)  expect_perf("perf_cleared", 32'd0, 4'd0);
            if (i == 16) expect_perf("perf_16", 32'd16, 4'd15);
            end_step();
        end
        begin_step();
        expect_perf("perf_sat", 32'd20, 4'd15);
        end_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
